axi_lite_mem_arbiter: RTL

//  2:1 AXI-Lite arbiter in front of the single-ported AXI-Lite SRAM. M0 = IFU (read-only), M1 = LSU (read+write).

---
 rtl/axi_lite_mem_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_mem_arbiter.sv
// 2:1 AXI-Lite arbiter: M0 (IFU, read-only) and M1 (LSU, read/write) share
// one AXI-Lite SRAM slave. Only one transaction is outstanding at a time.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   m0_ar*/m0_r*        M0 read address / read data
//   m1_ar*/m1_r*        M1 read address / read data
//   m1_aw*/m1_w*/m1_b*  M1 write address / write data / write response
//   s_*                 slave side of all five channels
module axi_lite_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // M0 read
  input  logic [AW-1:0]   m0_araddr,
  input  logic            m0_arvalid,
  output logic            m0_arready,
  output logic [DW-1:0]   m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  // M1 read
  input  logic [AW-1:0]   m1_araddr,
  input  logic            m1_arvalid,
  output logic            m1_arready,
  output logic [DW-1:0]   m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  // M1 write
  input  logic [AW-1:0]   m1_awaddr,
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  output logic [1:0]      m1_bresp,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  // slave
  output logic [AW-1:0]   s_araddr,
  output logic            s_arvalid,
  input  logic            s_arready,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic            s_rvalid,
  output logic            s_rready,
  output logic [AW-1:0]   s_awaddr,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  output logic            s_wvalid,
  input  logic            s_wready,
  input  logic [1:0]      s_bresp,
  input  logic            s_bvalid,
  output logic            s_bready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WR1  = 2'd3
  } state_e;

  state_e state_q, state_d;
  // last_q: 0 = M0 granted last, 1 = M1 granted last
  logic   last_q, last_d;
  logic   a_done_q, a_done_d;
  logic   w_done_q, w_done_d;

  logic req0, req1r, req1w, req1;

  assign req0  = m0_arvalid;
  assign req1r = m1_arvalid;
  assign req1w = m1_awvalid & m1_wvalid;
  assign req1  = req1r | req1w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      a_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_done_q <= a_done_d;
      w_done_q <= w_done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    a_done_d = a_done_q;
    w_done_d = w_done_q;
    unique case (state_q)
      IDLE: begin
        // M0 wins if alone, or on a tie when M1 went last
        if (req0 && (!req1 || last_q)) begin
          state_d = RD0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = req1w ? WR1 : RD1;
          last_d  = 1'b1;
        end
      end
      RD0, RD1: begin
        if (s_arvalid && s_arready)
          a_done_d = 1'b1;
        if (s_rvalid && s_rready) begin
          state_d  = IDLE;
          a_done_d = 1'b0;
        end
      end
      WR1: begin
        if (s_awvalid && s_awready)
          a_done_d = 1'b1;
        if (s_wvalid && s_wready)
          w_done_d = 1'b1;
        if (s_bvalid && s_bready) begin
          state_d  = IDLE;
          a_done_d = 1'b0;
          w_done_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    unique case (state_q)
      IDLE: ;
      RD0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid & ~a_done_q;
        m0_arready = s_arready & ~a_done_q;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
      end
      RD1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid & ~a_done_q;
        m1_arready = s_arready & ~a_done_q;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
      end
      WR1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~a_done_q;
        m1_awready = s_awready & ~a_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done_q;
        m1_wready  = s_wready & ~w_done_q;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
      end
    endcase
  end

endmodule
